// File: rtl/axi2apb_req_sched.sv
// Pops commands from the write/read command FIFOs and issues them one at a time
// to the APB master. The priority side is bounded by a starvation limit.
module axi2apb_req_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int PRIO_WRITE = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  wr_empty_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_pop_o,
  input  logic                  rd_empty_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rd_pop_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [DATA_WIDTH-1:0] req_data_o,
  output logic                  req_write_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_burst_cnt;
  logic            w_p_ne, w_o_ne, w_load, w_go, w_burst_full;
  logic            w_sel_p, w_sel_o, w_sel_wr, w_sel_rd, w_sel_any;

  assign w_p_ne       = (PRIO_WRITE != 0) ? !wr_empty_i : !rd_empty_i;
  assign w_o_ne       = (PRIO_WRITE != 0) ? !rd_empty_i : !wr_empty_i;
  assign w_burst_full = (r_burst_cnt == CW'(MAX_BURST));
  assign w_load       = (r_state == S_IDLE) | ((r_state == S_ISSUE) & req_ready_i);
  // Pops are suppressed during reset and flush so no command is lost from a FIFO.
  assign w_go         = w_load & rst_ni & !flush_i;
  assign w_sel_o      = w_go & w_o_ne & (!w_p_ne | w_burst_full);
  assign w_sel_p      = w_go & w_p_ne & !w_sel_o;
  assign w_sel_wr     = (PRIO_WRITE != 0) ? w_sel_p : w_sel_o;
  assign w_sel_rd     = (PRIO_WRITE != 0) ? w_sel_o : w_sel_p;
  assign w_sel_any    = w_sel_p | w_sel_o;

  assign wr_pop_o = w_sel_wr;
  assign rd_pop_o = w_sel_rd;

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)     w_state_nxt = S_IDLE;
    else if (w_load) w_state_nxt = w_sel_any ? S_ISSUE : S_IDLE;
  end

  // output logic
  always_comb begin
    req_valid_o = (r_state == S_ISSUE);
    busy_o      = (r_state == S_ISSUE) | !wr_empty_i | !rd_empty_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_data_o  <= '0;
      req_write_o <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      if (w_sel_any) begin
        req_data_o  <= w_sel_wr ? wr_data_i : rd_data_i;
        req_write_o <= w_sel_wr;
      end
      if (flush_i || w_sel_o)
        r_burst_cnt <= '0;
      else if (w_sel_p)
        r_burst_cnt <= !w_o_ne ? '0 : (w_burst_full ? r_burst_cnt : r_burst_cnt + CW'(1));
    end
  end
endmodule

// File: tb/tb_axi2apb_req_sched.sv
// Randomized and directed bench for axi2apb_req_sched; FIFOs and the scheduler
// are modelled with queues and a starvation streak counter.
module tb_axi2apb_req_sched;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 0;
  logic          rst_n, flush, wr_empty, rd_empty, ready;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_pop, rd_pop, valid, wr_flag, busy;
  logic [DW-1:0] data;

  axi2apb_req_sched #(.DATA_WIDTH(DW), .PRIO_WRITE(1), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .wr_empty_i(wr_empty), .wr_data_i(wr_data), .wr_pop_o(wr_pop),
    .rd_empty_i(rd_empty), .rd_data_i(rd_data), .rd_pop_o(rd_pop),
    .req_valid_o(valid), .req_ready_i(ready), .req_data_o(data),
    .req_write_o(wr_flag), .busy_o(busy));

  always #5 clk = ~clk;

  logic [DW-1:0] wq[$], rq[$];
  logic          acc_q[$];
  int            n_chk = 0, n_fail = 0;

  // reference state
  logic          m_valid, m_write, m_zero;
  logic [DW-1:0] m_data;
  int            m_streak;
  logic          e_wp, e_rp, e_o_has;

  task automatic drive_fifo();
    wr_empty = (wq.size() == 0);
    rd_empty = (rq.size() == 0);
    wr_data  = (wq.size() != 0) ? wq[0] : '0;
    rd_data  = (rq.size() != 0) ? rq[0] : '0;
  endtask

  // One clock: predict and compare combinational outputs at negedge, then advance model.
  task automatic cyc();
    logic p_has, take_o;
    drive_fifo();
    @(negedge clk);
    e_wp = 0; e_rp = 0;
    p_has = (wq.size() != 0);
    e_o_has = (rq.size() != 0);
    if (rst_n && !flush && (!m_valid || ready) && (p_has || e_o_has)) begin
      take_o = e_o_has && (!p_has || m_streak == MB);
      e_wp = !take_o;
      e_rp = take_o;
    end
    n_chk++; if (wr_pop !== e_wp) begin n_fail++; $display("FAIL wr_pop t=%0t: got %b expected %b", $time, wr_pop, e_wp); end
    n_chk++; if (rd_pop !== e_rp) begin n_fail++; $display("FAIL rd_pop t=%0t: got %b expected %b", $time, rd_pop, e_rp); end
    n_chk++; if (valid !== m_valid) begin n_fail++; $display("FAIL valid t=%0t: got %b expected %b", $time, valid, m_valid); end
    n_chk++;
    if (busy !== (m_valid || wq.size() != 0 || rq.size() != 0)) begin
      n_fail++; $display("FAIL busy t=%0t: got %b expected %b", $time, busy, m_valid || wq.size() != 0 || rq.size() != 0);
    end
    if (m_valid || m_zero) begin
      n_chk++; if (data !== m_data) begin n_fail++; $display("FAIL data t=%0t: got %h expected %h", $time, data, m_data); end
      n_chk++; if (wr_flag !== m_write) begin n_fail++; $display("FAIL write t=%0t: got %b expected %b", $time, wr_flag, m_write); end
    end
    if (valid === 1'b1 && ready) acc_q.push_back(wr_flag);
    @(posedge clk); #1;
    if (!rst_n) begin
      m_valid = 0; m_streak = 0; m_data = '0; m_write = 0; m_zero = 1;
    end else if (flush) begin
      m_valid = 0; m_streak = 0;
    end else if (e_wp || e_rp) begin
      m_valid = 1; m_zero = 0; m_write = e_wp;
      m_data  = e_wp ? wq.pop_front() : rq.pop_front();
      if (e_rp || !e_o_has) m_streak = 0;
      else if (m_streak < MB) m_streak++;
    end else if (!m_valid || ready) begin
      m_valid = 0;
    end
    drive_fifo();
  endtask

  task automatic drain();
    ready = 1; flush = 0;
    for (int i = 0; i < 40; i++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; ready = 0;
    repeat (3) cyc();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_chk++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got valid=%b busy=%b expected 0 0", valid, busy); end
    end
  endtask

  task automatic test_single();
    wq.push_back(32'hA5A5_0001);
    ready = 1;
    cyc();
    n_chk++; if (valid !== 1'b1 || data !== 32'hA5A5_0001 || wr_flag !== 1'b1) begin
      n_fail++; $display("FAIL single: got v=%b d=%h w=%b expected 1 a5a50001 1", valid, data, wr_flag);
    end
    cyc();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", valid); end
  endtask

  task automatic test_back_to_back();
    logic exp_seq[10];
    exp_seq = '{1,1,1,1,0,1,1,1,1,0};
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    for (int i = 0; i < 2; i++) rq.push_back($urandom);
    ready = 1;
    acc_q.delete();
    for (int i = 0; i < 11; i++) cyc();
    n_chk++; if (acc_q.size() != 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", acc_q.size()); end
    for (int i = 0; i < 10 && i < acc_q.size(); i++) begin
      n_chk++; if (acc_q[i] !== exp_seq[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %b expected %b", i, acc_q[i], exp_seq[i]); end
    end
    drain();
  endtask

  task automatic test_stall();
    logic [DW-1:0] v0, v1;
    v0 = $urandom; v1 = $urandom;
    wq.push_back(v0); wq.push_back(v1); rq.push_back($urandom);
    ready = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_chk++; if (data !== v0 || wr_flag !== 1'b1 || valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold: got d=%h w=%b v=%b expected %h 1 1", data, wr_flag, valid, v0);
      end
    end
    ready = 1;
    cyc();
    n_chk++; if (data !== v1) begin n_fail++; $display("FAIL stall_next: got %h expected %h", data, v1); end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) wq.push_back($urandom);
    rq.push_back(32'h0000_BEEF);
    ready = 1;
    repeat (4) cyc();   // fourth write now held, streak at limit
    ready = 0; flush = 1;
    cyc();
    flush = 0;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", valid); end
    cyc();
    n_chk++; if (valid !== 1'b1 || wr_flag !== 1'b1) begin
      n_fail++; $display("FAIL flush_restart: got v=%b w=%b expected 1 1", valid, wr_flag);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) wq.push_back($urandom);
    rq.push_back($urandom); rq.push_back($urandom);
    ready = 1;
    repeat (3) cyc();
    rst_n = 0;
    cyc();
    n_chk++; if (valid !== 1'b0 || data !== '0 || wr_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got v=%b d=%h w=%b expected 0 0 0", valid, data, wr_flag);
    end
    rst_n = 1;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) wq.push_back($urandom);
      if ($urandom_range(0, 3) == 0) rq.push_back($urandom);
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      cyc();
    end
    drain();
  endtask

  initial begin
    rst_n = 0; flush = 0; ready = 0;
    m_valid = 0; m_write = 0; m_zero = 0; m_data = '0; m_streak = 0;
    drive_fifo();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
